// File: rtl/fmlarb_sched.sv
// fmlarb_sched: four-master round-robin scheduler for one FML slave port.
// Grants one master at a time, drives the slave address phase until early
// acknowledge, times the ack pulse (write: eack+1, read: eack+6) and steers
// the 4-beat burst between the owner and the slave.
//
// Ports:
//   sys_clk, sys_rst_n         clock, asynchronous active-low reset
//   m_adr/m_stb/m_we/m_sel/m_dw  per-master request bundles (master i at slice i)
//   m_ack                      one-cycle ack to the owner, first data beat
//   m_dr                       read data broadcast (= s_dr)
//   s_adr/s_stb/s_we/s_sel/s_dw  slave-side request and write data
//   s_eack, s_dr               slave early ack and read data
//   grant                      index of current owner
//   busy                       high whenever a transaction is in flight
module fmlarb_sched #(
    parameter int unsigned ADR_W  = 26,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned SEL_W  = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [4*ADR_W-1:0]    m_adr,
    input  logic [3:0]            m_stb,
    input  logic [3:0]            m_we,
    input  logic [4*SEL_W-1:0]    m_sel,
    input  logic [4*DATA_W-1:0]   m_dw,
    output logic [3:0]            m_ack,
    output logic [DATA_W-1:0]     m_dr,
    output logic [ADR_W-1:0]      s_adr,
    output logic                  s_stb,
    output logic                  s_we,
    input  logic                  s_eack,
    output logic [SEL_W-1:0]      s_sel,
    output logic [DATA_W-1:0]     s_dw,
    input  logic [DATA_W-1:0]     s_dr,
    output logic [1:0]            grant,
    output logic                  busy
);

    localparam int unsigned GNT_W  = 2;
    localparam int unsigned WCNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        DATA = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [GNT_W-1:0]    grant_q, grant_d;
    logic [GNT_W-1:0]    ptr_q, ptr_d;
    logic [GNT_W-1:0]    beat_q, beat_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                rd_q, rd_d;
    logic [3:0]          m_ack_q, m_ack_d;
    logic                s_stb_q, s_stb_d;
    logic                busy_q, busy_d;
    logic                wbeat_q, wbeat_d;
    logic [GNT_W-1:0]    winner;

    // Per-master slices of the flat request buses
    logic [ADR_W-1:0]    adr_a [4];
    logic [SEL_W-1:0]    sel_a [4];
    logic [DATA_W-1:0]   dw_a  [4];

    for (genvar i = 0; i < 4; i++) begin : g_unpack
        assign adr_a[i] = m_adr[i*ADR_W  +: ADR_W];
        assign sel_a[i] = m_sel[i*SEL_W  +: SEL_W];
        assign dw_a[i]  = m_dw [i*DATA_W +: DATA_W];
    end

    // Round-robin pick: scan from the farthest offset down so the request
    // closest to ptr (offset 0) is the last to overwrite winner.
    always_comb begin
        winner = ptr_q;
        for (int j = 3; j >= 0; j--) begin
            if (m_stb[ptr_q + GNT_W'(j)]) begin
                winner = ptr_q + GNT_W'(j);
            end
        end
    end

    // Slave-side muxes follow the current grant at all times
    assign s_adr = adr_a[grant_q];
    assign s_we  = m_we[grant_q];
    assign s_dw  = dw_a[grant_q];
    assign s_sel = wbeat_q ? sel_a[grant_q] : '0;
    assign m_dr  = s_dr;

    assign m_ack = m_ack_q;
    assign s_stb = s_stb_q;
    assign busy  = busy_q;
    assign grant = grant_q;

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        wcnt_d  = wcnt_q;
        rd_d    = rd_q;
        m_ack_d = '0;

        unique case (state_q)
            IDLE: begin
                if (|m_stb) begin
                    grant_d = winner;
                    ptr_d   = winner + GNT_W'(1);
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (s_eack) begin
                    beat_d = '0;
                    if (s_we) begin
                        rd_d    = 1'b0;
                        state_d = DATA;
                    end else begin
                        rd_d    = 1'b1;
                        wcnt_d  = WCNT_W'(4);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wcnt_q == '0) begin
                    beat_d  = '0;
                    state_d = DATA;
                end else begin
                    wcnt_d = wcnt_q - WCNT_W'(1);
                end
            end
            DATA: begin
                beat_d = beat_q + GNT_W'(1);
                if (beat_q == GNT_W'(3)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Ack coincides with the first DATA beat only
        if (state_d == DATA && state_q != DATA) begin
            m_ack_d[grant_q] = 1'b1;
        end

        s_stb_d = (state_d == ADDR);
        busy_d  = (state_d != IDLE);
        wbeat_d = (state_d == DATA) && !rd_d;
    end

    // State and output registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
            wcnt_q  <= '0;
            rd_q    <= 1'b0;
            m_ack_q <= '0;
            s_stb_q <= 1'b0;
            busy_q  <= 1'b0;
            wbeat_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            wcnt_q  <= wcnt_d;
            rd_q    <= rd_d;
            m_ack_q <= m_ack_d;
            s_stb_q <= s_stb_d;
            busy_q  <= busy_d;
            wbeat_q <= wbeat_d;
        end
    end

endmodule

// File: tb/tb_fmlarb_sched.sv
// Bench for fmlarb_sched: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-timeline model of the scheduler.
module tb_fmlarb_sched;

    localparam int unsigned ADR_W  = 26;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned SEL_W  = 8;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst_n;
    logic [4*ADR_W-1:0]   m_adr;
    logic [3:0]           m_stb;
    logic [3:0]           m_we;
    logic [4*SEL_W-1:0]   m_sel;
    logic [4*DATA_W-1:0]  m_dw;
    logic [3:0]           m_ack;
    logic [DATA_W-1:0]    m_dr;
    logic [ADR_W-1:0]     s_adr;
    logic                 s_stb;
    logic                 s_we;
    logic                 s_eack;
    logic [SEL_W-1:0]     s_sel;
    logic [DATA_W-1:0]    s_dw;
    logic [DATA_W-1:0]    s_dr;
    logic [1:0]           grant;
    logic                 busy;

    fmlarb_sched #(.ADR_W(ADR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .m_adr     (m_adr),
        .m_stb     (m_stb),
        .m_we      (m_we),
        .m_sel     (m_sel),
        .m_dw      (m_dw),
        .m_ack     (m_ack),
        .m_dr      (m_dr),
        .s_adr     (s_adr),
        .s_stb     (s_stb),
        .s_we      (s_we),
        .s_eack    (s_eack),
        .s_sel     (s_sel),
        .s_dw      (s_dw),
        .s_dr      (s_dr),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Model: a transaction is idle, in its address phase, or transferring
    // with its data window starting at posedge number data_start.
    typedef enum int {M_IDLE, M_ADDR, M_XFER} mmode_t;

    int      n_checks;
    int      n_fail;
    int      cyc;
    mmode_t  mode;
    int      owner;
    int      ptr;
    int      data_start;
    bit      rd;
    bit      granted;
    logic [3:0] e_ack;
    bit      e_busy;
    bit      e_stb;
    bit      e_wr;
    int      grants[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mode  = M_IDLE;
        owner = 0;
        ptr   = 0;
        rd    = 1'b0;
    endtask

    // Advance the model by one posedge using the inputs present at that edge
    task automatic model_step();
        bit found;
        granted = 1'b0;
        case (mode)
            M_IDLE: begin
                found = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    if (!found && m_stb[(ptr + j) % 4]) begin
                        owner = (ptr + j) % 4;
                        found = 1'b1;
                    end
                end
                if (found) begin
                    ptr     = (owner + 1) % 4;
                    mode    = M_ADDR;
                    granted = 1'b1;
                end
            end
            M_ADDR: begin
                if (s_eack) begin
                    rd         = !m_we[owner];
                    data_start = cyc + (rd ? 5 : 0);
                    mode       = M_XFER;
                end
            end
            default: begin
                if (cyc == data_start + 4) mode = M_IDLE;
            end
        endcase
    endtask

    task automatic model_outputs();
        e_busy = (mode != M_IDLE);
        e_stb  = (mode == M_ADDR);
        e_ack  = (mode == M_XFER && cyc == data_start) ? 4'(1 << owner) : 4'b0000;
        e_wr   = (mode == M_XFER) && !rd && (cyc >= data_start);
    endtask

    task automatic compare_all();
        check("m_ack", 64'(m_ack), 64'(e_ack));
        check("busy",  64'(busy),  64'(e_busy));
        check("s_stb", 64'(s_stb), 64'(e_stb));
        check("grant", 64'(grant), 64'(owner));
        check("s_adr", 64'(s_adr), 64'(m_adr[owner*ADR_W +: ADR_W]));
        check("s_we",  64'(s_we),  64'(m_we[owner]));
        check("s_dw",  s_dw,       m_dw[owner*DATA_W +: DATA_W]);
        check("s_sel", 64'(s_sel), e_wr ? 64'(m_sel[owner*SEL_W +: SEL_W]) : 64'd0);
        check("m_dr",  m_dr,       s_dr);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
        cyc++;
        if (!sys_rst_n) begin
            model_reset();
            granted = 1'b0;
        end else begin
            model_step();
        end
        model_outputs();
        compare_all();
    endtask

    // Serve traffic with eack in the first address cycle until back in IDLE
    task automatic run_to_idle(input int budget);
        int n;
        n = 0;
        do begin
            s_eack = e_stb;
            tick();
            n++;
            m_stb = m_stb & ~e_ack;
        end while (mode != M_IDLE && n < budget);
        s_eack = 1'b0;
        check("run_to_idle_timeout", 64'(mode == M_IDLE), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        sys_rst_n = 1'b0;
        m_stb     = '0;
        m_we      = '0;
        s_eack    = 1'b0;
        s_dr      = '0;
        for (int i = 0; i < 4; i++) begin
            m_adr[i*ADR_W +: ADR_W]   = ADR_W'($urandom);
            m_sel[i*SEL_W +: SEL_W]   = SEL_W'($urandom);
            m_dw[i*DATA_W +: DATA_W]  = {$urandom, $urandom};
        end
        model_reset();
        model_outputs();

        // Reset state
        tick();
        tick();
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_s_stb", 64'(s_stb), 64'd0);
        check("rst_m_ack", 64'(m_ack), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_s_sel", 64'(s_sel), 64'd0);
        check("rst_s_adr", 64'(s_adr), 64'(m_adr[0 +: ADR_W]));
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Spurious eack in IDLE
        s_eack = 1'b1;
        tick();
        s_eack = 1'b0;
        tick();
        check("idle_eack_busy", 64'(busy), 64'd0);

        // Single write, master 2
        m_we  = 4'b0100;
        m_stb = 4'b0100;
        m_sel[2*SEL_W +: SEL_W] = 8'hA5;
        tick();
        check("wr_grant", 64'(grant), 64'd2);
        check("wr_s_stb", 64'(s_stb), 64'd1);
        tick();
        tick();
        s_eack = 1'b1;
        tick();
        check("wr_ack",  64'(m_ack), 64'h4);
        check("wr_sel0", 64'(s_sel), 64'hA5);
        s_eack = 1'b0;
        m_stb  = 4'b0000;
        for (int b = 1; b < 4; b++) begin
            tick();
            check("wr_sel_beat", 64'(s_sel), 64'hA5);
            check("wr_noack",    64'(m_ack), 64'd0);
        end
        tick();
        check("wr_idle_busy",  64'(busy),  64'd0);
        check("wr_idle_grant", 64'(grant), 64'd2);
        check("wr_idle_sel",   64'(s_sel), 64'd0);

        // Single read, master 1, with a spurious eack during WAIT
        m_we  = 4'b0000;
        m_stb = 4'b0010;
        tick();
        check("rd_grant", 64'(grant), 64'd1);
        s_eack = 1'b1;
        tick();
        s_eack = 1'b0;
        for (int w = 2; w <= 5; w++) begin
            s_eack = (w == 4);
            tick();
            check("rd_wait_noack", 64'(m_ack), 64'd0);
            check("rd_wait_busy",  64'(busy),  64'd1);
        end
        s_eack = 1'b0;
        for (int b = 0; b < 4; b++) begin
            logic [DATA_W-1:0] d;
            d    = DATA_W'((b + 1) * 'h11);
            s_dr = d;
            tick();
            check("rd_ack", 64'(m_ack), (b == 0) ? 64'h2 : 64'd0);
            check("rd_dr",  m_dr, d);
            m_stb = 4'b0000;
        end
        tick();
        check("rd_idle_busy", 64'(busy), 64'd0);

        // Pointer skip: master 0 served, then 0 and 3 compete
        m_we  = 4'b1001;
        m_stb = 4'b0001;
        run_to_idle(20);
        m_stb = 4'b1001;
        tick();
        check("skip_first",  64'(grant), 64'd3);
        run_to_idle(20);
        tick();
        check("skip_second", 64'(grant), 64'd0);
        run_to_idle(20);

        // Round-robin fairness with all masters re-requesting after their ack
        m_we  = 4'b1111;
        m_stb = 4'b1111;
        grants.delete();
        for (int c = 0; c < 80; c++) begin
            s_eack = e_stb;
            tick();
            if (granted) grants.push_back(owner);
            m_stb = 4'b1111 & ~e_ack;
        end
        run_to_idle(20);
        m_stb = 4'b0000;
        check("rr_count", 64'(grants.size() >= 8), 64'd1);
        check("rr_first", 64'(grants[0]), 64'd1);
        for (int g = 1; g < grants.size(); g++) begin
            check("rr_order", 64'(grants[g]), 64'((1 + g) % 4));
        end
        tick();

        // Async reset during WAIT
        m_we  = 4'b0000;
        m_stb = 4'b0100;
        tick();
        check("rst_wait_grant", 64'(grant), 64'd2);
        s_eack = 1'b1;
        tick();
        s_eack = 1'b0;
        tick();
        #3;
        sys_rst_n = 1'b0;
        #1;
        check("arst_s_stb", 64'(s_stb), 64'd0);
        check("arst_m_ack", 64'(m_ack), 64'd0);
        check("arst_busy",  64'(busy),  64'd0);
        check("arst_grant", 64'(grant), 64'd0);
        model_reset();
        model_outputs();
        m_stb = 4'b1100;
        tick();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tick();
        check("arst_regrant", 64'(grant), 64'd2);
        check("arst_noack",   64'(m_ack), 64'd0);
        run_to_idle(20);
        run_to_idle(20);
        m_stb = 4'b0000;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            s_eack = e_stb ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            s_dr   = {$urandom, $urandom};
            for (int i = 0; i < 4; i++) begin
                m_sel[i*SEL_W +: SEL_W]  = SEL_W'($urandom);
                m_dw[i*DATA_W +: DATA_W] = {$urandom, $urandom};
                if (!m_stb[i] && $urandom_range(0, 3) == 0) begin
                    m_stb[i] = 1'b1;
                    m_we[i]  = 1'($urandom);
                    m_adr[i*ADR_W +: ADR_W] = ADR_W'($urandom);
                end
            end
            tick();
            m_stb = m_stb & ~e_ack;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fmlarb_sched.md
# fmlarb_sched

Four-master round-robin scheduler for one FML (fast memory link) slave port in front of the SDRAM controller. Requesters present address and strobe. The block grants one master at a time and drives the slave address phase until early acknowledge. It then times the ack pulse (write: eack+1, read: eack+6, matching tim_cas=1) and steers the 4-beat burst data between the owner and the slave.

## Interface
- ADR_W, 26, FML address width
- DATA_W, 64, data width per beat
- SEL_W, 8, byte-select width (DATA_W/8)
- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- m_adr  in  4*ADR_W  master addresses; master i at [i*ADR_W +: ADR_W]
- m_stb  in  4  per-master request strobe, held until that master's ack
- m_we  in  4  per-master write enable
- m_sel  in  4*SEL_W  per-master byte selects (write beats)
- m_dw  in  4*DATA_W  per-master write data
- m_ack  out  4  one-cycle ack pulse to the owner; marks first data beat
- m_dr  out  DATA_W  read data, broadcast = s_dr
- s_adr  out  ADR_W  slave address = m_adr of granted master
- s_stb  out  1  slave strobe
- s_we  out  1  slave write enable = m_we of granted master
- s_eack  in  1  slave early acknowledge
- s_sel  out  SEL_W  byte selects; owner's m_sel in write DATA beats, else 0
- s_dw  out  DATA_W  owner's m_dw (muxed by grant at all times)
- s_dr  in  DATA_W  slave read data
- grant  out  2  index of current owner
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, ADDR, WAIT, DATA. Registers: state, grant[1:0], ptr[1:0] (round-robin pointer), wcnt[2:0], beat[1:0], rd (latched ~we at eack).
- IDLE: if any m_stb, pick the first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4). Register it into grant. Set ptr <= winner+1 (mod 4). Go to ADDR. If no m_stb, stay; grant and ptr hold.
- ADDR: s_stb=1, s_adr/s_we muxed from grant. Wait for s_eack.
  - On s_eack with write: go to DATA, beat=0.
  - On s_eack with read: load wcnt=4, rd=1, go to WAIT.
  - The owner's m_stb is ignored after eack (masked) until its ack.
- WAIT (read only): decrement wcnt each cycle. When wcnt==0 go to DATA, beat=0.
- DATA: 4 cycles, beat 0..3. m_ack[grant]=1 only in beat 0.
  - Write: s_sel = owner's m_sel, s_dw = owner's m_dw.
  - Read: m_dr = s_dr, and the owner samples all 4 beats.
  - After beat 3, go to IDLE.
- Only one transaction is in flight. No grant change occurs outside IDLE. A master whose m_stb drops before grant is simply not considered. Dropping m_stb during ADDR is illegal (FML rule) and is not checked.
- m_ack is never asserted to a non-owner and never more than once per transaction.

## Timing
- Reset (async, sys_rst_n=0): state=IDLE, grant=0, ptr=0, wcnt=0, beat=0. Outputs: m_ack=0, s_stb=0, s_sel=0, busy=0, s_adr/s_we/s_dw reflect master 0. Reset mid-burst aborts immediately; no ack is issued after release.
- Let cycle t be the IDLE cycle with m_stb seen.
  - t+1: grant valid, s_stb=1.
  - s_eack at cycle k (k>=t+1).
  - Write: m_ack at k+1, write beats k+1..k+4, IDLE at k+5.
  - Read: WAIT k+1..k+5, m_ack and first s_dr beat at k+6, beats k+6..k+9, IDLE at k+10.
- Minimum spacing between successive grants: write 6 cycles, read 11 cycles when eack arrives in the first ADDR cycle.
- Simultaneous requests in IDLE: exactly one winner per round-robin. A request arriving in the same cycle the block returns to IDLE is arbitrated that cycle.
- s_eack outside ADDR is ignored.

## Test plan
- Single write, master 2: m_stb=4'b0100, m_we[2]=1, s_eack 3 cycles after s_stb rises → m_ack=4'b0100 exactly one cycle after eack. s_sel=m_sel[2] for 4 cycles, then busy=0 and grant=2.
- Single read, master 1: s_eack at cycle k, s_dr=0x11,0x22,0x33,0x44 on k+6..k+9 → m_ack=4'b0010 at k+6 only, m_dr follows s_dr, IDLE at k+10.
- Round-robin fairness: all four m_stb held high, each re-asserting after its ack → grant sequence 0,1,2,3,0,… with no master granted twice before the others.
- Pointer skip: after master 0 is served, only m_stb[0] and m_stb[3] are asserted → master 3 wins, then master 0.
- Spurious eack: pulse s_eack in IDLE and in WAIT → no state change, no m_ack, read ack still at original k+6.
- Async reset during WAIT: drop sys_rst_n for one cycle → s_stb=0, m_ack=0, busy=0 immediately. No ack appears afterwards, and the next request gets grant from ptr=0.
